mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter between the CPU control unit's memory request path and a debug/loader port, in front of the single memory backend (flash/RAM controller). It latches one request at a time, forwards it to the backend, and waits for the backend's done. It then returns a registered done pulse and read data to the owning requester. Fairness is round-robin, with a debug lock that can hold the CPU off the bus while a program is loaded.

## Interface
- `ADDR_WIDTH`, default 16: memory address width.
- `DATA_WIDTH`, default 8: data width.
- `TIMEOUT`, default 255: maximum BUSY cycles before abort; 0 disables the timeout; 8-bit counter.

Ports (reset is `reset`, synchronous, active-low; clock is `clock`):
- `clock` in 1: clock, rising edge.
- `reset` in 1: synchronous active-low reset.
- `cpu_op` in `mem_ctrl_op_e` (2): CPU request, held level until `cpu_done`.
- `cpu_addr` in ADDR_WIDTH: CPU address.
- `cpu_wdata` in DATA_WIDTH: CPU write data.
- `cpu_rdata` out DATA_WIDTH: read data, valid while `cpu_done`=1.
- `cpu_done` out 1: one-cycle completion pulse to CPU.
- `dbg_op`, `dbg_addr`, `dbg_wdata`, `dbg_rdata`, `dbg_done`: same as the CPU port, for debug/loader.
- `dbg_lock` in 1: while 1, the CPU is never granted.
- `mem_op` out `mem_ctrl_op_e` (2): backend request.
- `mem_addr` out ADDR_WIDTH: backend address.
- `mem_wdata` out DATA_WIDTH: backend write data.
- `mem_rdata` in DATA_WIDTH: backend read data, valid with `mem_done`.
- `mem_done` in 1: backend completion.
- `owner` out 1: current or last grant (0=CPU, 1=debug).
- `timeout_err` out 1: one-cycle pulse on abort.

## Operation
- All outputs are registered.
- Op decode:
  - MEM_READ and MEM_WRITE are requests.
  - MEM_NOP and the unused encoding are no request.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Drive `mem_op`=MEM_NOP.
  - If exactly one port is eligible, grant it.
  - If both are eligible, grant the port other than `last_owner`.
  - The CPU is eligible only if `dbg_lock`=0.
  - On grant: latch op, addr, and wdata of the winner into issue registers; set `owner` and `last_owner`; clear the timeout counter; go to BUSY.
- BUSY:
  - Drive `mem_op`/`mem_addr`/`mem_wdata` from the issue registers.
  - Requester input changes are ignored.
  - Counter increments each cycle.
  - On `mem_done`=1: capture `mem_rdata` into the owner's rdata register and go to RESP.
  - Else, if `TIMEOUT`≠0 and the counter reaches `TIMEOUT`-1: load the owner's rdata with all-ones, pulse `timeout_err`, and go to RESP.
- RESP:
  - Owner's done=1 for exactly this cycle.
  - `mem_op`=MEM_NOP.
  - Go to IDLE.
- Non-owner done is always 0. Non-owner rdata holds its last value.
- `dbg_lock` asserted during a CPU transaction does not abort it. The lock takes effect at the next IDLE arbitration.
- WRITE transactions also go through RESP. rdata is loaded with `mem_rdata` as sampled.

## Timing
- Reset values:
  - state IDLE
  - `mem_op`=MEM_NOP, `mem_addr`=0, `mem_wdata`=0
  - `cpu_done`=`dbg_done`=0
  - `cpu_rdata`=`dbg_rdata`=0
  - `owner`=0
  - `last_owner`=1, so the CPU wins the first tie
  - `timeout_err`=0, counter=0
- Reset mid-transaction: abort immediately, with no done pulse and no `timeout_err`. `mem_op`=MEM_NOP in the cycle after reset is sampled low.
- Grant latency: request visible in IDLE cycle T → `mem_op` valid in cycle T+1.
- Completion: `mem_done` in cycle D → requester done and rdata in cycle D+1 → IDLE in D+2 → earliest next `mem_op` in D+3.
- `mem_op` drops to MEM_NOP in cycle D+1.
- `mem_done` in the first BUSY cycle is legal, giving a minimum transaction of 3 cycles (BUSY, RESP, IDLE).
- Requester contract: hold op stable until done; drop to MEM_NOP in the cycle after done. The CPU control unit's registered op satisfies this, so no stale re-grant occurs.
- Timeout: with no `mem_done`, the abort happens after exactly `TIMEOUT` BUSY cycles. `mem_done` in the same cycle as the counter limit counts as a normal completion; `mem_done` wins.
- A `mem_done` pulse arriving in IDLE or RESP is ignored.

## Test plan
- CPU only: `cpu_op`=READ, addr 0x0012; backend returns 0xA5 after 3 cycles → `mem_op`=READ/0x0012 one cycle after the request, `cpu_done`=1 with `cpu_rdata`=0xA5 for one cycle, `dbg_done` stays 0.
- Tie, round-robin: both ports request READ in the same cycle after reset → CPU granted first (`owner`=0), debug second (`owner`=1). Repeating the tie alternates grants.
- `dbg_lock`=1 with both ports requesting repeatedly → only debug is granted and the CPU waits. Dropping the lock → CPU granted at the next IDLE.
- Debug WRITE 0x3C to 0x0100 while `cpu_addr`/`cpu_op` toggle during BUSY → `mem_addr`=0x0100 and `mem_wdata`=0x3C stay stable until `mem_done`, then `dbg_done` pulses once.
- Timeout with `TIMEOUT`=4 and `mem_done` never asserted → RESP after 4 BUSY cycles, `timeout_err` and `cpu_done` pulse together, `cpu_rdata`=0xFF.
- Reset low during BUSY → next cycle IDLE with `mem_op`=MEM_NOP, no done pulse. A subsequent tie is granted to the CPU.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug-loader) arbiter in front of a single memory backend.
// One transaction at a time, round-robin on ties, debug lock, BUSY timeout.
package mem_ctrl_pkg;
   typedef enum logic [1:0] {
      MEM_NOP   = 2'b00,
      MEM_READ  = 2'b01,
      MEM_WRITE = 2'b10,
      MEM_RSVD  = 2'b11
   } mem_ctrl_op_e;
endpackage

module mem_arbiter
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clock,
   input  logic                  reset,
   input  mem_ctrl_op_e          cpu_op,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_done,
   input  mem_ctrl_op_e          dbg_op,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   input  logic [DATA_WIDTH-1:0] dbg_wdata,
   output logic [DATA_WIDTH-1:0] dbg_rdata,
   output logic                  dbg_done,
   input  logic                  dbg_lock,
   output mem_ctrl_op_e          mem_op,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_done,
   output logic                  owner,
   output logic                  timeout_err
);

   localparam bit         TO_EN   = (TIMEOUT != 0);
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   state_e                state_q,      state_d;
   mem_ctrl_op_e          mem_op_q,     mem_op_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q,  mem_wdata_d;
   logic [DATA_WIDTH-1:0] cpu_rdata_q,  cpu_rdata_d;
   logic [DATA_WIDTH-1:0] dbg_rdata_q,  dbg_rdata_d;
   logic                  cpu_done_q,   cpu_done_d;
   logic                  dbg_done_q,   dbg_done_d;
   logic                  owner_q,      owner_d;
   logic                  last_owner_q, last_owner_d;
   logic                  terr_q,       terr_d;
   logic [7:0]            cnt_q,        cnt_d;

   logic                  cpu_elig;
   logic                  dbg_elig;
   logic                  grant_dbg;
   logic                  finish;
   logic [DATA_WIDTH-1:0] resp_data;

   function automatic logic is_req(input mem_ctrl_op_e op);
      return (op == MEM_READ) || (op == MEM_WRITE);
   endfunction

   always_comb begin
      state_d      = state_q;
      mem_op_d     = mem_op_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      cpu_rdata_d  = cpu_rdata_q;
      dbg_rdata_d  = dbg_rdata_q;
      cpu_done_d   = 1'b0;
      dbg_done_d   = 1'b0;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      terr_d       = 1'b0;
      cnt_d        = cnt_q;
      finish       = 1'b0;
      resp_data    = mem_rdata;

      cpu_elig  = is_req(cpu_op) && !dbg_lock;
      dbg_elig  = is_req(dbg_op);
      // On a tie the port that did not win last time goes first.
      grant_dbg = dbg_elig && (!cpu_elig || !last_owner_q);

      unique case (state_q)
         ST_IDLE: begin
            mem_op_d = MEM_NOP;
            if (cpu_elig || dbg_elig) begin
               if (grant_dbg) begin
                  mem_op_d    = dbg_op;
                  mem_addr_d  = dbg_addr;
                  mem_wdata_d = dbg_wdata;
               end else begin
                  mem_op_d    = cpu_op;
                  mem_addr_d  = cpu_addr;
                  mem_wdata_d = cpu_wdata;
               end
               owner_d      = grant_dbg;
               last_owner_d = grant_dbg;
               cnt_d        = 8'd0;
               state_d      = ST_BUSY;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q + 8'd1;
            // A backend completion on the limit cycle still counts as success.
            if (mem_done) begin
               finish = 1'b1;
            end else if (TO_EN && (cnt_q == TO_LAST)) begin
               finish    = 1'b1;
               resp_data = '1;
               terr_d    = 1'b1;
            end
            if (finish) begin
               mem_op_d = MEM_NOP;
               state_d  = ST_RESP;
               if (owner_q) begin
                  dbg_rdata_d = resp_data;
                  dbg_done_d  = 1'b1;
               end else begin
                  cpu_rdata_d = resp_data;
                  cpu_done_d  = 1'b1;
               end
            end
         end
         ST_RESP: begin
            mem_op_d = MEM_NOP;
            state_d  = ST_IDLE;
         end
         default: begin
            mem_op_d = MEM_NOP;
            state_d  = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         mem_op_q     <= MEM_NOP;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
         cpu_done_q   <= 1'b0;
         dbg_done_q   <= 1'b0;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         terr_q       <= 1'b0;
         cnt_q        <= 8'd0;
      end else begin
         state_q      <= state_d;
         mem_op_q     <= mem_op_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
         cpu_done_q   <= cpu_done_d;
         dbg_done_q   <= dbg_done_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         terr_q       <= terr_d;
         cnt_q        <= cnt_d;
      end
   end

   assign mem_op      = mem_op_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign cpu_rdata   = cpu_rdata_q;
   assign dbg_rdata   = dbg_rdata_q;
   assign cpu_done    = cpu_done_q;
   assign dbg_done    = dbg_done_q;
   assign owner       = owner_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model driving expectations per cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;
   import mem_ctrl_pkg::*;

   localparam int TO = 4;

   logic         clock = 1'b0;
   logic         reset;
   mem_ctrl_op_e cpu_op, dbg_op, mem_op;
   logic [15:0]  cpu_addr, dbg_addr, mem_addr;
   logic [7:0]   cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
   logic         cpu_done, dbg_done, dbg_lock, mem_done, owner, timeout_err;

   mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .cpu_op(cpu_op), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
      .dbg_op(dbg_op), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
      .dbg_lock(dbg_lock),
      .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_done(mem_done),
      .owner(owner), .timeout_err(timeout_err)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Expected outputs for the current cycle
   bit           chk_en = 1'b0;
   mem_ctrl_op_e exp_mem_op;
   logic [15:0]  exp_mem_addr;
   logic [7:0]   exp_mem_wdata, exp_cpu_rdata, exp_dbg_rdata;
   bit           exp_busy, exp_cpu_done, exp_dbg_done, exp_owner, exp_terr;

   // Reference model: last grant, returned data, pending requests per port (0=CPU, 1=debug)
   int           m_last, m_owner, jd;
   logic [7:0]   m_crd, m_drd;
   bit           m_lock, auto_req;
   bit           pend [2];
   mem_ctrl_op_e pop  [2];
   logic [15:0]  paddr[2];
   logic [7:0]   pwd  [2];

   // Observations of the last transaction, for literal checks
   mem_ctrl_op_e obs_op;
   logic [15:0]  obs_addr;
   logic [7:0]   obs_wdata, obs_crd, obs_drd;
   bit           obs_cdone, obs_ddone, obs_terr, obs_owner, obs_granted;
   int           obs_busy;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got %0h want %0h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         chk("mem_op", mem_op, exp_mem_op);
         if (exp_busy) begin
            chk("mem_addr", mem_addr, exp_mem_addr);
            chk("mem_wdata", mem_wdata, exp_mem_wdata);
         end
         chk("cpu_done", cpu_done, exp_cpu_done);
         chk("dbg_done", dbg_done, exp_dbg_done);
         chk("cpu_rdata", cpu_rdata, exp_cpu_rdata);
         chk("dbg_rdata", dbg_rdata, exp_dbg_rdata);
         chk("owner", owner, exp_owner);
         chk("timeout_err", timeout_err, exp_terr);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_exp(input mem_ctrl_op_e op, input logic [15:0] a, input logic [7:0] d,
                          input bit busy, input bit cd, input bit dd, input bit te);
      exp_mem_op    = op;
      exp_mem_addr  = a;
      exp_mem_wdata = d;
      exp_busy      = busy;
      exp_cpu_done  = cd;
      exp_dbg_done  = dd;
      exp_terr      = te;
      exp_owner     = m_owner[0];
      exp_cpu_rdata = m_crd;
      exp_dbg_rdata = m_drd;
   endtask

   task automatic model_reset();
      m_last  = 1;
      m_owner = 0;
      m_crd   = 8'h00;
      m_drd   = 8'h00;
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      jd      = -1;
   endtask

   task automatic set_req(input int p, input mem_ctrl_op_e op, input logic [15:0] a,
                          input logic [7:0] d);
      pend[p]  = 1'b1;
      pop[p]   = op;
      paddr[p] = a;
      pwd[p]   = d;
   endtask

   // A pending port holds its request; others idle, or scribble while not being served.
   task automatic drive_port(input int p, input bit scribble);
      mem_ctrl_op_e o;
      logic [15:0]  a;
      logic [7:0]   d;
      if (pend[p]) begin
         o = pop[p]; a = paddr[p]; d = pwd[p];
      end else begin
         a = 16'($urandom);
         d = 8'($urandom);
         if (scribble)     o = mem_ctrl_op_e'(2'($urandom_range(3)));
         else if (jd == p) o = MEM_NOP;
         else              o = ($urandom_range(1) == 1) ? MEM_RSVD : MEM_NOP;
      end
      if (p == 0) begin
         cpu_op = o; cpu_addr = a; cpu_wdata = d;
      end else begin
         dbg_op = o; dbg_addr = a; dbg_wdata = d;
      end
   endtask

   // Called in a cycle where the arbiter is idle; runs one arbitration and, on a grant,
   // the whole transaction. lat = BUSY cycle (1-based) carrying mem_done; >TO means none.
   task automatic idle_cycle(input int lat_in, input int lock_in, input int rd_in);
      bit           el_c, el_d;
      int           w, lat, nb;
      logic [7:0]   rdv, val;
      mem_ctrl_op_e op;
      logic [15:0]  ad;
      logic [7:0]   wd;
      if (auto_req)
         for (int p = 0; p < 2; p++)
            if (!pend[p] && jd != p && $urandom_range(9) < 6)
               set_req(p, ($urandom_range(1) == 1) ? MEM_READ : MEM_WRITE,
                       16'($urandom), 8'($urandom));
      m_lock = (lock_in < 0) ? ($urandom_range(9) < 3) : lock_in[0];
      set_exp(MEM_NOP, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive_port(0, 1'b0);
      drive_port(1, 1'b0);
      dbg_lock  = m_lock;
      mem_done  = ($urandom_range(3) == 0);
      mem_rdata = 8'($urandom);
      jd = -1;
      el_c = pend[0] && !m_lock;
      el_d = pend[1];
      obs_granted = el_c || el_d;
      if (!obs_granted) begin
         step();
         return;
      end
      w  = (el_c && el_d) ? (1 - m_last) : (el_d ? 1 : 0);
      op = pop[w]; ad = paddr[w]; wd = pwd[w];
      m_owner = w;
      m_last  = w;
      lat = (lat_in < 0) ? int'($urandom_range(1, 6)) : lat_in;
      nb  = (lat <= TO) ? lat : TO;
      obs_busy = 0;
      rdv = 8'h00;
      for (int b = 1; b <= nb; b++) begin
         step();
         set_exp(op, ad, wd, 1'b1, 1'b0, 1'b0, 1'b0);
         if (b == 1) begin
            obs_op = mem_op; obs_addr = mem_addr; obs_wdata = mem_wdata;
         end
         if (mem_op != MEM_NOP) obs_busy++;
         drive_port(1 - w, 1'b1);
         drive_port(w, 1'b0);
         dbg_lock  = 1'($urandom_range(1));
         mem_rdata = (b == nb && rd_in >= 0) ? rd_in[7:0] : 8'($urandom);
         rdv       = mem_rdata;
         mem_done  = (b == lat);
      end
      val = (lat <= TO) ? rdv : 8'hFF;
      if (w == 0) m_crd = val;
      else        m_drd = val;
      step();
      set_exp(MEM_NOP, ad, wd, 1'b0, w == 0, w == 1, lat > TO);
      if (mem_op != MEM_NOP) obs_busy++;
      obs_cdone = cpu_done; obs_ddone = dbg_done; obs_terr = timeout_err;
      obs_crd = cpu_rdata;  obs_drd = dbg_rdata;  obs_owner = owner;
      mem_done  = 1'($urandom_range(1));
      mem_rdata = 8'($urandom);
      dbg_lock  = 1'($urandom_range(1));
      pend[w] = 1'b0;
      step();
      jd = w;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog t=%0t got running want finished", $time);
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      cpu_op = MEM_NOP; cpu_addr = '0; cpu_wdata = '0;
      dbg_op = MEM_NOP; dbg_addr = '0; dbg_wdata = '0;
      dbg_lock = 1'b0; mem_done = 1'b0; mem_rdata = '0;
      auto_req = 1'b0;
      model_reset();
      step();
      set_exp(MEM_NOP, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_en = 1'b1;
      chk("rst_mem_op", mem_op, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_owner", owner, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      step();
      reset = 1'b1;

      // Tie after reset: CPU first, then debug
      set_req(0, MEM_READ, 16'h0040, 8'h00);
      set_req(1, MEM_READ, 16'h0080, 8'h00);
      idle_cycle(2, 0, -1);
      chk("tie1_owner", obs_owner, 0);
      idle_cycle(2, 0, -1);
      chk("tie2_owner", obs_owner, 1);
      idle_cycle(1, 0, -1);

      // CPU only read
      set_req(0, MEM_READ, 16'h0012, 8'hEE);
      idle_cycle(3, 0, 8'hA5);
      chk("cpu_only_op", obs_op, MEM_READ);
      chk("cpu_only_addr", obs_addr, 16'h0012);
      chk("cpu_only_done", obs_cdone, 1);
      chk("cpu_only_rdata", obs_crd, 8'hA5);
      chk("cpu_only_dbg_done", obs_ddone, 0);
      chk("cpu_only_busy", obs_busy, 3);
      idle_cycle(1, 0, -1);

      // Tie after a CPU grant goes to debug, then CPU
      set_req(0, MEM_READ, 16'h0011, 8'h00);
      set_req(1, MEM_READ, 16'h0022, 8'h00);
      idle_cycle(1, 0, -1);
      chk("tie3_owner", obs_owner, 1);
      idle_cycle(1, 0, -1);
      chk("tie4_owner", obs_owner, 0);
      idle_cycle(1, 0, -1);

      // Debug lock holds the CPU off
      set_req(0, MEM_READ, 16'h0033, 8'h00);
      set_req(1, MEM_READ, 16'h0044, 8'h00);
      idle_cycle(2, 1, -1);
      chk("lock1_owner", obs_owner, 1);
      idle_cycle(2, 1, -1);
      chk("lock_nogrant", obs_granted, 0);
      set_req(1, MEM_WRITE, 16'h0055, 8'h66);
      idle_cycle(2, 1, -1);
      chk("lock2_owner", obs_owner, 1);
      idle_cycle(2, 0, -1);
      chk("unlock_owner", obs_owner, 0);

      // Debug write with CPU inputs toggling; completion on the timeout limit cycle
      set_req(1, MEM_WRITE, 16'h0100, 8'h3C);
      idle_cycle(TO, 0, 8'h77);
      chk("dbgw_op", obs_op, MEM_WRITE);
      chk("dbgw_addr", obs_addr, 16'h0100);
      chk("dbgw_wdata", obs_wdata, 8'h3C);
      chk("dbgw_done", obs_ddone, 1);
      chk("dbgw_cpu_done", obs_cdone, 0);
      chk("dbgw_terr", obs_terr, 0);
      chk("dbgw_busy", obs_busy, 4);
      chk("dbgw_rdata", obs_drd, 8'h77);

      // Timeout
      set_req(0, MEM_READ, 16'h0200, 8'h00);
      idle_cycle(9, 0, -1);
      chk("to_busy", obs_busy, 4);
      chk("to_terr", obs_terr, 1);
      chk("to_done", obs_cdone, 1);
      chk("to_rdata", obs_crd, 8'hFF);

      // Reset during BUSY
      set_exp(MEM_NOP, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      cpu_op = MEM_NOP; dbg_op = MEM_READ; dbg_addr = 16'h0300; dbg_wdata = 8'h00;
      dbg_lock = 1'b0; mem_done = 1'b0;
      step();
      m_owner = 1;
      m_last  = 1;
      set_exp(MEM_READ, 16'h0300, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      step();
      model_reset();
      set_exp(MEM_NOP, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rstmid_op", mem_op, MEM_NOP);
      chk("rstmid_dbg_done", dbg_done, 0);
      chk("rstmid_terr", timeout_err, 0);
      chk("rstmid_dbg_rdata", dbg_rdata, 8'h00);
      reset = 1'b1;
      set_req(0, MEM_READ, 16'h0400, 8'h00);
      set_req(1, MEM_READ, 16'h0500, 8'h00);
      idle_cycle(1, 0, -1);
      chk("rstmid_tie_owner", obs_owner, 0);

      // Randomized traffic
      auto_req = 1'b1;
      repeat (400) idle_cycle(-1, -1, -1);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
